decoder_nto2n_seq: RTL and testbench

//   Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with a valid/ready input handshake.

---
 rtl/decoder_pkg.sv | 30 +++
 rtl/decoder_nto2n.sv | 15 +
 rtl/decoder_nto2n_seq.sv | 138 +++++++++++++
 tb/tb_decoder_nto2n_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types and the one-hot helper for the registered N-to-2^N select decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    LEVEL = 2'b00,
    PULSE = 2'b01,
    SCAN  = 2'b10,
    RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    PULSE_S,
    SCAN_S
  } state_e;

  localparam int unsigned MaxSelW = 8;
  localparam int unsigned MaxOutW = 1 << MaxSelW;

  // Callers truncate the result to their own line count.
  function automatic logic [MaxOutW-1:0] onehot_dec(input logic [MaxSelW-1:0] sel,
                                                    input logic               en);
    logic [MaxOutW-1:0] v;
    v = '0;
    if (en) v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_nto2n.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder; all-zero when en is low.
module decoder_nto2n
  import decoder_pkg::*;
#(
  parameter  int unsigned SEL_W = 2,
  localparam int unsigned OUT_W = 1 << SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [OUT_W-1:0] out
);

  assign out = OUT_W'(onehot_dec(MaxSelW'(sel), en));

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered one-hot select generator with LEVEL, PULSE and SCAN modes behind a
// valid/ready input handshake.
module decoder_nto2n_seq
  import decoder_pkg::*;
#(
  parameter  int unsigned SEL_W     = 2,
  parameter  int unsigned PULSE_LEN = 1,
  parameter  int unsigned DWELL     = 4,
  localparam int unsigned OUT_W     = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned PCW = $clog2(PULSE_LEN + 1);
  localparam int unsigned DCW = $clog2(DWELL + 1);
  localparam logic [PCW-1:0] PulseLast = PCW'(PULSE_LEN - 1);
  localparam logic [DCW-1:0] DwellLast = DCW'(DWELL - 1);

  mode_e            mode_in;
  state_e           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [PCW-1:0]   pcnt_q, pcnt_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic             out_valid_q, busy_q;
  logic             accept, scan_start, dec_en;
  logic [SEL_W-1:0] dec_sel;
  logic [OUT_W-1:0] dec_out;

  assign mode_in = mode_e'(mode);

  assign in_ready = rst_n && enable && (state_q == IDLE || state_q == HOLD) &&
                    (mode_in == LEVEL || mode_in == PULSE);
  assign accept   = in_valid && in_ready;

  assign scan_start = enable && (mode_in == SCAN) && (state_q == IDLE || state_q == HOLD);

  // Scan entry reuses the decoder to load line 0.
  assign dec_sel = scan_start ? '0 : in_sel;
  assign dec_en  = accept || scan_start;

  decoder_nto2n #(
    .SEL_W (SEL_W)
  ) u_dec (
    .sel (dec_sel),
    .en  (dec_en),
    .out (dec_out)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
    if (!enable) begin
      state_d = IDLE;
      out_d   = '0;
      pcnt_d  = '0;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE, HOLD: begin
          if (scan_start) begin
            state_d = SCAN_S;
            out_d   = dec_out;
            dcnt_d  = '0;
          end else if (accept) begin
            state_d = (mode_in == PULSE) ? PULSE_S : HOLD;
            out_d   = dec_out;
            pcnt_d  = '0;
          end else if (mode_in == RSVD) begin
            state_d = IDLE;
            out_d   = '0;
          end
        end
        PULSE_S: begin
          if (pcnt_q == PulseLast) begin
            state_d = IDLE;
            out_d   = '0;
            pcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + PCW'(1);
          end
        end
        SCAN_S: begin
          if (mode_in != SCAN) begin
            state_d = IDLE;
            out_d   = '0;
            pcnt_d  = '0;
            dcnt_d  = '0;
          end else if (dcnt_q == DwellLast) begin
            dcnt_d = '0;
            out_d  = {out_q[OUT_W-2:0], out_q[OUT_W-1]};
          end else begin
            dcnt_d = dcnt_q + DCW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          out_d   = '0;
          pcnt_d  = '0;
          dcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= '0;
      pcnt_q      <= '0;
      dcnt_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      pcnt_q      <= pcnt_d;
      dcnt_q      <= dcnt_d;
      out_valid_q <= |out_d;
      busy_q      <= (state_d == PULSE_S) || (state_d == SCAN_S);
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Directed bench: a vector table drives a 2-bit instance through LEVEL/PULSE/RSVD/SCAN,
// hand-written sequences exercise SCAN wrap, reset and enable abort on a 3-bit instance.
module tb_decoder_nto2n_seq;
  import decoder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_rst_n, a_en, a_vld, a_rdy, a_ov, a_busy;
  logic [1:0] a_mode, a_sel;
  logic [3:0] a_out;

  logic       b_rst_n, b_en, b_vld, b_rdy, b_ov, b_busy;
  logic [1:0] b_mode;
  logic [2:0] b_sel;
  logic [7:0] b_out;

  decoder_nto2n_seq #(
    .SEL_W     (2),
    .PULSE_LEN (3),
    .DWELL     (4)
  ) u_a (
    .clk       (clk),
    .rst_n     (a_rst_n),
    .enable    (a_en),
    .mode      (a_mode),
    .in_valid  (a_vld),
    .in_ready  (a_rdy),
    .in_sel    (a_sel),
    .out       (a_out),
    .out_valid (a_ov),
    .busy      (a_busy)
  );

  decoder_nto2n_seq #(
    .SEL_W     (3),
    .PULSE_LEN (4),
    .DWELL     (2)
  ) u_b (
    .clk       (clk),
    .rst_n     (b_rst_n),
    .enable    (b_en),
    .mode      (b_mode),
    .in_valid  (b_vld),
    .in_ready  (b_rdy),
    .in_sel    (b_sel),
    .out       (b_out),
    .out_valid (b_ov),
    .busy      (b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants on both instances, sampled mid-cycle.
  always @(negedge clk) begin
    chk("a_onehot0", 32'($onehot0(a_out)), 32'd1);
    chk("a_ov_eq_or", 32'(a_ov), 32'(|a_out));
    chk("b_onehot0", 32'($onehot0(b_out)), 32'd1);
    chk("b_ov_eq_or", 32'(b_ov), 32'(|b_out));
  end

  typedef struct {
    logic       en;
    logic [1:0] mode;
    logic       vld;
    logic [1:0] sel;
    logic       rdy;   // in_ready before the edge
    logic [3:0] out;   // out after the edge
    logic       busy;  // busy after the edge
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [1:0] mode, input logic vld,
                              input logic [1:0] sel, input logic rdy, input logic [3:0] out,
                              input logic busy);
    vec_t v;
    v.en = en; v.mode = mode; v.vld = vld; v.sel = sel;
    v.rdy = rdy; v.out = out; v.busy = busy;
    return v;
  endfunction

  localparam int NVec = 29;
  vec_t vecs[NVec];

  initial begin
    logic [7:0] exp8;

    vecs[0]  = mk(1, LEVEL, 1, 2, 1, 4'b0100, 0);
    vecs[1]  = mk(1, LEVEL, 0, 0, 1, 4'b0100, 0);
    vecs[2]  = mk(1, LEVEL, 1, 3, 1, 4'b1000, 0);
    vecs[3]  = mk(0, LEVEL, 0, 0, 0, 4'b0000, 0);
    vecs[4]  = mk(1, PULSE, 1, 1, 1, 4'b0010, 1);
    vecs[5]  = mk(1, PULSE, 1, 2, 0, 4'b0010, 1);
    vecs[6]  = mk(1, PULSE, 1, 2, 0, 4'b0010, 1);
    vecs[7]  = mk(1, PULSE, 1, 2, 0, 4'b0000, 0);
    vecs[8]  = mk(1, PULSE, 1, 2, 1, 4'b0100, 1);
    vecs[9]  = mk(1, PULSE, 0, 0, 0, 4'b0100, 1);
    vecs[10] = mk(1, PULSE, 0, 0, 0, 4'b0100, 1);
    vecs[11] = mk(1, PULSE, 0, 0, 0, 4'b0000, 0);
    vecs[12] = mk(1, LEVEL, 1, 0, 1, 4'b0001, 0);
    vecs[13] = mk(1, PULSE, 1, 3, 1, 4'b1000, 1);
    vecs[14] = mk(1, RSVD,  1, 1, 0, 4'b1000, 1);
    vecs[15] = mk(1, RSVD,  1, 1, 0, 4'b1000, 1);
    vecs[16] = mk(1, RSVD,  1, 1, 0, 4'b0000, 0);
    vecs[17] = mk(1, RSVD,  1, 1, 0, 4'b0000, 0);
    vecs[18] = mk(1, LEVEL, 1, 1, 1, 4'b0010, 0);
    vecs[19] = mk(1, RSVD,  1, 2, 0, 4'b0000, 0);
    vecs[20] = mk(1, SCAN,  1, 3, 0, 4'b0001, 1);
    vecs[21] = mk(1, SCAN,  0, 0, 0, 4'b0001, 1);
    vecs[22] = mk(1, SCAN,  0, 0, 0, 4'b0001, 1);
    vecs[23] = mk(1, SCAN,  0, 0, 0, 4'b0001, 1);
    vecs[24] = mk(1, SCAN,  0, 0, 0, 4'b0010, 1);
    vecs[25] = mk(1, LEVEL, 0, 0, 0, 4'b0000, 0);
    vecs[26] = mk(1, LEVEL, 1, 2, 1, 4'b0100, 0);
    vecs[27] = mk(1, SCAN,  1, 1, 0, 4'b0001, 1);
    vecs[28] = mk(0, SCAN,  0, 0, 0, 4'b0000, 0);

    a_rst_n = 0; a_en = 1; a_mode = LEVEL; a_vld = 1; a_sel = 2;
    b_rst_n = 0; b_en = 0; b_mode = LEVEL; b_vld = 0; b_sel = 0;

    // Reset held with in_valid high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out", 32'(a_out), 32'd0);
      chk("rst_ov", 32'(a_ov), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_rdy", 32'(a_rdy), 32'd0);
    end
    a_rst_n = 1; b_rst_n = 1; a_vld = 0;
    tick();
    chk("rdy_after_rst", 32'(a_rdy), 32'd1);
    chk("out_after_rst", 32'(a_out), 32'd0);

    for (int i = 0; i < NVec; i++) begin
      a_en = vecs[i].en; a_mode = vecs[i].mode; a_vld = vecs[i].vld; a_sel = vecs[i].sel;
      #1;
      chk($sformatf("v%0d_rdy", i), 32'(a_rdy), 32'(vecs[i].rdy));
      tick();
      chk($sformatf("v%0d_out", i), 32'(a_out), 32'(vecs[i].out));
      chk($sformatf("v%0d_ov", i), 32'(a_ov), 32'(|vecs[i].out));
      chk($sformatf("v%0d_busy", i), 32'(a_busy), 32'(vecs[i].busy));
    end
    a_en = 0; a_vld = 0; a_mode = LEVEL;

    // SCAN with DWELL=2 over 8 lines, through the wrap.
    b_en = 1; b_mode = SCAN; b_vld = 1; b_sel = 5;
    for (int i = 0; i < 18; i++) begin
      tick();
      exp8 = 8'h01 << ((i / 2) % 8);
      chk($sformatf("scan%0d_out", i), 32'(b_out), 32'(exp8));
      chk($sformatf("scan%0d_busy", i), 32'(b_busy), 32'd1);
      chk($sformatf("scan%0d_rdy", i), 32'(b_rdy), 32'd0);
    end
    b_mode = LEVEL; b_vld = 0;
    tick();
    chk("scan_exit_out", 32'(b_out), 32'd0);
    chk("scan_exit_busy", 32'(b_busy), 32'd0);

    // Reset in the middle of a scan.
    b_mode = SCAN;
    tick(); tick(); tick();
    chk("scan2_out", 32'(b_out), 32'h02);
    b_rst_n = 0; b_mode = LEVEL;
    #1;
    chk("rst_low_rdy", 32'(b_rdy), 32'd0);
    tick();
    chk("scan_rst_out", 32'(b_out), 32'd0);
    chk("scan_rst_ov", 32'(b_ov), 32'd0);
    chk("scan_rst_busy", 32'(b_busy), 32'd0);
    b_rst_n = 1;
    #1;
    chk("scan_rst_rdy", 32'(b_rdy), 32'd1);

    // enable dropped during cycle 2 of a 4-cycle pulse.
    b_mode = PULSE; b_vld = 1; b_sel = 5;
    tick();
    chk("abort_c1_out", 32'(b_out), 32'h20);
    chk("abort_c1_busy", 32'(b_busy), 32'd1);
    b_vld = 0;
    tick();
    chk("abort_c2_out", 32'(b_out), 32'h20);
    b_en = 0;
    tick();
    chk("abort_out", 32'(b_out), 32'd0);
    chk("abort_busy", 32'(b_busy), 32'd0);
    b_en = 1;
    #1;
    chk("abort_idle_rdy", 32'(b_rdy), 32'd1);

    // Full 4-cycle pulse afterwards.
    b_vld = 1; b_sel = 6;
    for (int i = 0; i < 5; i++) begin
      tick();
      b_vld = 0;
      exp8 = (i < 4) ? 8'h40 : 8'h00;
      chk($sformatf("pulse4_%0d_out", i), 32'(b_out), 32'(exp8));
    end

    b_en = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
